// File: rtl/logic_gate_sweep.sv
// Selectable N-input logic gate with single-shot evaluation and exhaustive truth-table sweep.
// Optional macro GATE_SWEEP_SIG_EN adds an 8-bit rotate/XOR signature of the sweep results.
module logic_gate_sweep #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             sweep_start,
    output logic             out_valid,
    output logic             out_y,
    output logic [WIDTH-1:0] out_vec,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [WIDTH:0]   ones_count
`ifdef GATE_SWEEP_SIG_EN
    ,
    output logic [7:0]       sweep_sig
`endif
);

    localparam int unsigned CW = WIDTH + 1;
    localparam logic [CW-1:0] LAST_VEC = CW'((2 ** WIDTH) - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    // Reduction of all input bits per gate select; reserved selects give 0.
    function automatic logic gate_eval(input logic [2:0] m, input logic [WIDTH-1:0] v);
        case (m)
            3'd0:    return &v;
            3'd1:    return |v;
            3'd2:    return ^v;
            3'd3:    return ~&v;
            3'd4:    return ~|v;
            3'd5:    return ~^v;
            default: return 1'b0;
        endcase
    endfunction

    state_t           r_state;
    logic [2:0]       r_mode;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic             r_out_y;
    logic [WIDTH-1:0] r_out_vec;
    logic             r_done;
    logic [WIDTH:0]   r_ones;
`ifdef GATE_SWEEP_SIG_EN
    logic [7:0]       r_sig;
`endif

    logic             w_accept;
    logic             w_eval;
    logic [WIDTH-1:0] w_vec;
    logic             w_sweep_y;
    logic             w_in_y;

    assign in_ready  = (r_state == S_IDLE) && !sweep_start;
    assign w_accept  = in_valid && in_ready;
    // Counter reaching 2^WIDTH marks the drain cycle that carries sweep_done.
    assign w_eval    = (r_state == S_SWEEP) && !r_cnt[WIDTH];
    assign w_vec     = r_cnt[WIDTH-1:0];
    assign w_sweep_y = gate_eval(r_mode, w_vec);
    assign w_in_y    = gate_eval(mode, in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= 3'd0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= 1'b0;
            r_out_vec   <= '0;
            r_done      <= 1'b0;
            r_ones      <= '0;
`ifdef GATE_SWEEP_SIG_EN
            r_sig       <= 8'd0;
`endif
        end else begin
            r_out_valid <= w_accept || w_eval;
            r_done      <= w_eval && (r_cnt == LAST_VEC);
            case (r_state)
                S_IDLE: begin
                    if (sweep_start) begin
                        r_state <= S_SWEEP;
                        r_mode  <= mode;
                        r_cnt   <= '0;
                        r_ones  <= '0;
`ifdef GATE_SWEEP_SIG_EN
                        r_sig   <= 8'd0;
`endif
                    end else if (in_valid) begin
                        r_out_y   <= w_in_y;
                        r_out_vec <= in_data;
                    end
                end
                S_SWEEP: begin
                    if (r_cnt[WIDTH]) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_out_y   <= w_sweep_y;
                        r_out_vec <= w_vec;
                        r_cnt     <= r_cnt + CW'(1);
                        r_ones    <= r_ones + CW'(w_sweep_y);
`ifdef GATE_SWEEP_SIG_EN
                        r_sig     <= {r_sig[6:0], r_sig[7]} ^ {7'b0, w_sweep_y};
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_y      = r_out_y;
    assign out_vec    = r_out_vec;
    assign sweep_busy = (r_state == S_SWEEP);
    assign sweep_done = r_done;
    assign ones_count = r_ones;
`ifdef GATE_SWEEP_SIG_EN
    assign sweep_sig  = r_sig;
`endif

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Directed bench for logic_gate_sweep: WIDTH=2 instance for single/sweep/reset scenarios,
// WIDTH=3 and WIDTH=8 instances for wide sweeps.
module tb_logic_gate_sweep;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [2:0] a_mode, b_mode, c_mode;
    logic       a_in_valid, b_in_valid, c_in_valid;
    logic [1:0] a_in_data;
    logic [2:0] b_in_data;
    logic [7:0] c_in_data;
    logic       a_in_ready, b_in_ready, c_in_ready;
    logic       a_start, b_start, c_start;
    logic       a_out_valid, b_out_valid, c_out_valid;
    logic       a_out_y, b_out_y, c_out_y;
    logic [1:0] a_out_vec;
    logic [2:0] b_out_vec;
    logic [7:0] c_out_vec;
    logic       a_busy, b_busy, c_busy;
    logic       a_done, b_done, c_done;
    logic [2:0] a_ones;
    logic [3:0] b_ones;
    logic [8:0] c_ones;
`ifdef GATE_SWEEP_SIG_EN
    logic [7:0] a_sig, b_sig, c_sig;
`endif

    logic_gate_sweep #(.WIDTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .sweep_start(a_start), .out_valid(a_out_valid), .out_y(a_out_y),
        .out_vec(a_out_vec), .sweep_busy(a_busy), .sweep_done(a_done), .ones_count(a_ones)
`ifdef GATE_SWEEP_SIG_EN
        , .sweep_sig(a_sig)
`endif
    );

    logic_gate_sweep #(.WIDTH(3)) u_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .sweep_start(b_start), .out_valid(b_out_valid), .out_y(b_out_y),
        .out_vec(b_out_vec), .sweep_busy(b_busy), .sweep_done(b_done), .ones_count(b_ones)
`ifdef GATE_SWEEP_SIG_EN
        , .sweep_sig(b_sig)
`endif
    );

    logic_gate_sweep #(.WIDTH(8)) u_c (
        .clk(clk), .rst_n(rst_n), .mode(c_mode), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_ready(c_in_ready), .sweep_start(c_start), .out_valid(c_out_valid), .out_y(c_out_y),
        .out_vec(c_out_vec), .sweep_busy(c_busy), .sweep_done(c_done), .ones_count(c_ones)
`ifdef GATE_SWEEP_SIG_EN
        , .sweep_sig(c_sig)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        a_mode = 3'd0; b_mode = 3'd0; c_mode = 3'd0;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        #12;
        checks++;
        if ({a_out_valid, a_out_y, a_out_vec, a_busy, a_done, a_ones} !== 9'd0) begin
            errors++;
            $display("FAIL reset_a: got %b required 0", {a_out_valid, a_out_y, a_out_vec, a_busy, a_done, a_ones});
        end
        checks++;
        if ({b_out_valid, b_busy, b_done, b_ones, c_out_valid, c_busy, c_done, c_ones} !== 19'd0) begin
            errors++;
            $display("FAIL reset_bc: got %b required 0", {b_out_valid, b_busy, b_done, b_ones, c_out_valid, c_busy, c_done, c_ones});
        end
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", a_in_ready);
        end
`ifdef GATE_SWEEP_SIG_EN
        checks++;
        if (a_sig !== 8'd0) begin
            errors++;
            $display("FAIL reset_sig: got %h required 00", a_sig);
        end
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    // Sweep on the WIDTH=2 instance; exp_y[k] is the hand-computed result for vector k.
    task automatic run_sweep_a(input string name, input logic [2:0] m, input logic [3:0] exp_y,
                               input logic [2:0] exp_ones, input bit with_in_valid, input bit repulse);
        logic [5:0] got, want;
`ifdef GATE_SWEEP_SIG_EN
        logic [7:0] sig_model;
        sig_model = 8'd0;
`endif
        a_mode = m; a_start = 1'b1; a_in_valid = with_in_valid; a_in_data = 2'd2;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_in_ready_on_start: got %b required 0", name, a_in_ready);
        end
        @(posedge clk) #1;
        a_start = 1'b0; a_in_valid = 1'b0; a_mode = m ^ 3'd1;
        checks++;
        if ({a_busy, a_out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL %s_first_cycle: busy,valid got %b required 10", name, {a_busy, a_out_valid});
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk) #1;
            got  = {a_out_valid, a_out_vec, a_out_y, a_done, a_busy};
            want = {1'b1, 2'(k), exp_y[k], (k == 3), 1'b1};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s_vec%0d: valid,vec,y,done,busy got %b required %b", name, k, got, want);
            end
`ifdef GATE_SWEEP_SIG_EN
            sig_model = {sig_model[6:0], sig_model[7]} ^ {7'b0, exp_y[k]};
`endif
            a_start = repulse && (k == 1);
        end
        checks++;
        if (a_ones !== exp_ones) begin
            errors++;
            $display("FAIL %s_ones: got %0d required %0d", name, a_ones, exp_ones);
        end
`ifdef GATE_SWEEP_SIG_EN
        checks++;
        if (a_sig !== sig_model) begin
            errors++;
            $display("FAIL %s_sig: got %h required %h", name, a_sig, sig_model);
        end
`endif
        @(posedge clk) #1;
        checks++;
        if ({a_out_valid, a_busy, a_done, a_in_ready, a_ones} !== {4'b0001, exp_ones}) begin
            errors++;
            $display("FAIL %s_after_done: valid,busy,done,ready,ones got %b required %b",
                     name, {a_out_valid, a_busy, a_done, a_in_ready, a_ones}, {4'b0001, exp_ones});
        end
    endtask

    task automatic test_single();
        a_mode = 3'd5; a_in_data = 2'b11; a_in_valid = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready: got %b required 1", a_in_ready);
        end
        @(posedge clk) #1;
        a_in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_out_y, a_out_vec} !== 4'b1111) begin
            errors++;
            $display("FAIL single_xnor: valid,y,vec got %b required 1111", {a_out_valid, a_out_y, a_out_vec});
        end
        @(posedge clk) #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: valid got %b required 0", a_out_valid);
        end
        a_mode = 3'd6; a_in_data = 2'b11; a_in_valid = 1'b1;
        @(posedge clk) #1;
        checks++;
        if ({a_out_valid, a_out_y, a_out_vec} !== 4'b1011) begin
            errors++;
            $display("FAIL single_reserved: valid,y,vec got %b required 1011", {a_out_valid, a_out_y, a_out_vec});
        end
        a_mode = 3'd3; a_in_data = 2'b01;
        @(posedge clk) #1;
        a_in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_out_y, a_out_vec} !== 4'b1101) begin
            errors++;
            $display("FAIL back_to_back_nand: valid,y,vec got %b required 1101", {a_out_valid, a_out_y, a_out_vec});
        end
        @(posedge clk) #1;
    endtask

    task automatic test_reset_mid_sweep();
        a_mode = 3'd1; a_start = 1'b1;
        @(posedge clk) #1;
        a_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_out_valid, a_out_vec} !== 3'b110) begin
            errors++;
            $display("FAIL rst_mid_at_vec2: valid,vec got %b required 110", {a_out_valid, a_out_vec});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_out_y, a_out_vec, a_busy, a_done, a_ones} !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b required 0", {a_out_valid, a_out_y, a_out_vec, a_busy, a_done, a_ones});
        end
        repeat (2) begin
            @(posedge clk) #1;
            checks++;
            if ({a_done, a_busy} !== 2'b00) begin
                errors++;
                $display("FAIL rst_mid_no_done: done,busy got %b required 00", {a_done, a_busy});
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        run_sweep_a("after_reset", 3'd1, 4'b1110, 3'd3, 1'b0, 1'b0);
    endtask

    task automatic test_w3_nor();
        int cyc, nvalid;
        b_mode = 3'd4; b_start = 1'b1;
        @(posedge clk) #1;
        b_start = 1'b0; cyc = 1; nvalid = 0;
        while (b_done !== 1'b1 && cyc < 40) begin
            @(posedge clk) #1;
            cyc++;
            if (b_out_valid === 1'b1) nvalid++;
        end
        checks++;
        if (cyc != 9 || nvalid != 8) begin
            errors++;
            $display("FAIL w3_done_timing: done cycle %0d results %0d required 9 and 8", cyc, nvalid);
        end
        checks++;
        if (b_ones !== 4'd1) begin
            errors++;
            $display("FAIL w3_nor_ones: got %0d required 1", b_ones);
        end
        @(posedge clk) #1;
    endtask

    task automatic test_w8_or();
        int cyc;
        c_mode = 3'd1; c_start = 1'b1;
        @(posedge clk) #1;
        c_start = 1'b0; cyc = 1;
        while (c_done !== 1'b1 && cyc < 400) begin
            @(posedge clk) #1;
            cyc++;
        end
        checks++;
        if (cyc != 257) begin
            errors++;
            $display("FAIL w8_done_timing: done cycle %0d required 257", cyc);
        end
        checks++;
        if (c_ones !== 9'd255 || c_out_vec !== 8'hFF) begin
            errors++;
            $display("FAIL w8_or_ones: ones %0d vec %h required 255 and ff", c_ones, c_out_vec);
        end
        @(posedge clk) #1;
        checks++;
        if ({c_busy, c_in_ready, c_ones} !== {2'b01, 9'd255}) begin
            errors++;
            $display("FAIL w8_hold: busy,ready,ones got %b required 01 and 255", {c_busy, c_in_ready, c_ones});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        run_sweep_a("sweep_or", 3'd1, 4'b1110, 3'd3, 1'b0, 1'b0);
        run_sweep_a("sweep_and", 3'd0, 4'b1000, 3'd1, 1'b0, 1'b0);
        run_sweep_a("sweep_xor", 3'd2, 4'b0110, 3'd2, 1'b0, 1'b0);
        run_sweep_a("sweep_nand", 3'd3, 4'b0111, 3'd3, 1'b0, 1'b0);
        test_single();
        run_sweep_a("start_priority_repulse", 3'd1, 4'b1110, 3'd3, 1'b1, 1'b1);
        test_reset_mid_sweep();
        test_w3_nor();
        test_w8_or();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_gate_sweep.md
LOGIC_GATE_SWEEP -- requirements
Module: logic_gate_sweep

Interface
REQ-001 Parameter: WIDTH, default 2, number of gate inputs; legal range 2..8.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: mode  input  3  gate select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
REQ-005 Port: in_valid  input  1  in_data valid this cycle.
REQ-006 Port: in_data  input  WIDTH  gate input vector.
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: sweep_start  input  1  request for an exhaustive truth-table sweep.
REQ-009 Port: out_valid  output  1  out_y and out_vec valid this cycle.
REQ-010 Port: out_y  output  1  gate result.
REQ-011 Port: out_vec  output  WIDTH  input vector that produced out_y.
REQ-012 Port: sweep_busy  output  1  a sweep is in progress.
REQ-013 Port: sweep_done  output  1  one-cycle pulse on the last sweep result.
REQ-014 Port: ones_count  output  WIDTH+1  number of sweep vectors whose result is 1.

Function
REQ-015 Gate function SHALL be the reduction of all WIDTH bits per mode; reserved modes SHALL yield 0.
REQ-016 FSM states SHALL be IDLE and SWEEP only.
REQ-017 in_ready SHALL equal (state==IDLE) AND NOT sweep_start; sweep_start has priority over in_valid.
REQ-018 Accepted input (in_valid & in_ready) SHALL appear on out_y/out_vec with out_valid high exactly 1 cycle later, for 1 cycle; no output backpressure.
REQ-019 sweep_start in IDLE SHALL latch mode, clear ones_count (and signature), set vector counter to 0, and enter SWEEP on the next edge.
REQ-020 In SWEEP, the counter SHALL evaluate vectors 0 .. 2^WIDTH-1 ascending, one per cycle, using the latched mode; mode changes during a sweep SHALL be ignored.
REQ-021 Each sweep result SHALL be output with 1-cycle latency (out_valid high); ones_count SHALL increment in the same cycle that a result of 1 is output.
REQ-022 sweep_done SHALL be high exactly in the cycle the result for vector 2^WIDTH-1 is output; ones_count is then final.
REQ-023 sweep_busy SHALL be high from the cycle after the sweep_start edge through the sweep_done cycle inclusive; a sweep spans 2^WIDTH+1 cycles from the start edge to sweep_done.
REQ-024 sweep_start asserted while busy SHALL be ignored; the counter SHALL not wrap or restart.
REQ-025 ones_count SHALL hold its final value until the next sweep start or reset; WIDTH+1 bits SHALL represent 2^WIDTH without overflow.
REQ-026 The FSM SHALL return to IDLE in the cycle after sweep_done; in_ready SHALL be high again in that cycle.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, out_valid 0, out_y 0, out_vec 0, sweep_busy 0, sweep_done 0, ones_count 0.
REQ-028 Reset mid-sweep SHALL abort the sweep with no sweep_done pulse; operation resumes on the first edge after rst_n goes high.

Configuration
REQ-029 Macro GATE_SWEEP_SIG_EN defined: SHALL add output sweep_sig (8 bits) = {sig[6:0],sig[7]} XOR {7'b0,y} per sweep result, cleared at sweep start and by reset, held after done.
REQ-030 GATE_SWEEP_SIG_EN undefined: sweep_sig port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 WIDTH=2, mode=OR, pulse sweep_start -> out_y 0,1,1,1 on out_vec 0..3; ones_count=3; sweep_done on 5th cycle after start edge; sweep_sig=0x07 when enabled.
REQ-032 WIDTH=2, sweeps in AND/XOR/NAND -> ones_count 1/2/3; WIDTH=3, NOR -> ones_count 1; WIDTH=8, OR -> ones_count 255.
REQ-033 Single inputs in IDLE: mode=XNOR, in_data=2'b11 -> out_y=1, out_valid 1 cycle later; mode=6 -> out_y=0.
REQ-034 sweep_start and in_valid in the same cycle -> in_ready=0, input not accepted, sweep runs; sweep_start re-pulsed mid-sweep -> ignored, exactly 4 results (WIDTH=2).
REQ-035 rst_n low during vector 2 of a WIDTH=2 sweep -> all outputs 0 immediately, no sweep_done; a new sweep then completes normally.
